// File: rtl/alu_nibble_serial_pkg.sv
// ---------------------------------------------------------------------------
// alu_nibble_serial_pkg
//
// Shared definitions for the nibble-serial ALU.
//   state_t     : controller states (IDLE, RUN, DONE)
//   SEL_*       : 74181 function selects that the tests use by name
// ---------------------------------------------------------------------------
package alu_nibble_serial_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Logic mode (m=1) selects
   localparam logic [3:0] SEL_NOT_A = 4'b0000;
   localparam logic [3:0] SEL_AND   = 4'b1011;
   localparam logic [3:0] SEL_XOR   = 4'b0110;

   // Arithmetic mode (m=0) selects
   localparam logic [3:0] SEL_ADD   = 4'b1001;
   localparam logic [3:0] SEL_SUB   = 4'b0110;

endpackage

// File: rtl/alu_nibble_serial_alu_4bit.sv
// ---------------------------------------------------------------------------
// ALU_4bit
//
// Combinational 74181-style 4-bit ALU slice. Data is active high and the
// carry is active low (cin=1 means no carry in, cout=0 means carry out).
//
// Ports:
//   a, b  [3:0]  operands
//   s     [3:0]  function select
//   m            mode: 1 = logic, 0 = arithmetic
//   cin          carry in (active low)
//   f     [3:0]  result
//   cout         carry out (active low)
// ---------------------------------------------------------------------------
module ALU_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] s,
   input  logic       m,
   input  logic       cin,
   output logic [3:0] f,
   output logic       cout
);

   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;

   // Each bit forms a propagate term p (an OR of A with a selected B
   // polarity) and a generate term g (A gated with a selected B polarity).
   // g is always a subset of p, so the arithmetic result is simply p + g
   // plus the active-high carry. In logic mode the internal carry is forced
   // high at every bit, which turns the sum bit into ~(p ^ g). The carry
   // chain itself never looks at m, so cout still reflects p/g in logic mode.
   always_comb begin
      p    = '0;
      g    = '0;
      c    = '0;
      f    = '0;
      c[0] = ~cin;
      for (int i = 0; i < 4; i++) begin
         p[i]     = a[i] | (b[i] & s[0]) | (~b[i] & s[1]);
         g[i]     = (a[i] & ~b[i] & s[2]) | (a[i] & b[i] & s[3]);
         c[i + 1] = g[i] | (p[i] & c[i]);
         f[i]     = p[i] ^ g[i] ^ (c[i] | m);
      end
      cout = ~c[4];
   end

endmodule

// File: rtl/alu_nibble_serial.sv
// ---------------------------------------------------------------------------
// alu_nibble_serial
//
// Wide ALU built from one reused 4-bit 74181-style slice. A command is
// accepted over a valid/ready port, then one nibble is processed per clock
// (LSB first) with the carry rippled through a register, and the full-width
// result is offered over a valid/ready output port.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   command valid
//   in_ready   block can accept a command (high only in IDLE)
//   a, b [W]   operands, latched at the accept edge
//   s [4]      function select, shared by every nibble
//   m          1 = logic, 0 = arithmetic
//   cin        carry into nibble 0 (active low)
//   out_valid  result valid (high in DONE)
//   out_ready  consumer accepts the result
//   f [W]      result
//   cout       carry out of the most significant nibble (active low)
//   busy       high in RUN or DONE
// ---------------------------------------------------------------------------
module alu_nibble_serial
   import alu_nibble_serial_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic [3:0]             s,
   input  logic                   m,
   input  logic                   cin,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   f,
   output logic                   cout,
   output logic                   busy
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t           state;
   state_t           next_state;
   logic             accept;
   logic             step;

   logic [W-1:0]     a_reg;
   logic [W-1:0]     b_reg;
   logic [3:0]       s_reg;
   logic             m_reg;
   logic             carry_reg;
   logic [W-1:0]     result_reg;
   logic [IDX_W-1:0] idx;

   logic [3:0]       alu_a;
   logic [3:0]       alu_b;
   logic [3:0]       alu_f;
   logic             alu_cout;

   // The slice always looks at the nibble selected by idx; {idx, 2'b00} is
   // idx*4, the bit offset of that nibble.
   assign alu_a = a_reg[{idx, 2'b00} +: 4];
   assign alu_b = b_reg[{idx, 2'b00} +: 4];

   ALU_4bit u_alu (
      .a    (alu_a),
      .b    (alu_b),
      .s    (s_reg),
      .m    (m_reg),
      .cin  (carry_reg),
      .f    (alu_f),
      .cout (alu_cout)
   );

   // Controller state register. Reset from any state drops straight back to
   // IDLE, which abandons an operation in flight without ever raising
   // out_valid for it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake outputs. in_ready is only high in IDLE, so a
   // command presented while DONE is being retired waits one more cycle and
   // is taken in the following IDLE cycle.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      step       = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               accept     = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (idx == LAST_IDX) begin
               next_state = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
            busy       = 1'b0;
         end
      endcase
   end

   // Datapath. Operands are captured once at the accept edge so that input
   // changes during RUN/DONE have no effect. Each RUN edge writes one result
   // nibble and moves the slice carry into carry_reg, which then feeds the
   // next nibble; after the last nibble carry_reg is the final carry out.
   // idx parks on the last nibble after RUN and is cleared by the next accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg      <= '0;
         b_reg      <= '0;
         s_reg      <= '0;
         m_reg      <= 1'b0;
         carry_reg  <= 1'b0;
         result_reg <= '0;
         idx        <= '0;
      end else if (accept) begin
         a_reg      <= a;
         b_reg      <= b;
         s_reg      <= s;
         m_reg      <= m;
         carry_reg  <= cin;
         result_reg <= '0;
         idx        <= '0;
      end else if (step) begin
         result_reg[{idx, 2'b00} +: 4] <= alu_f;
         carry_reg                     <= alu_cout;
         if (idx != LAST_IDX) begin
            idx <= idx + 1'b1;
         end
      end
   end

   assign f    = result_reg;
   assign cout = carry_reg;

endmodule
